// File: rtl/shift_issue_ctrl_pkg.sv
// rtl/shift_issue_ctrl_pkg.sv - shared constants and encodings for the shift issue block
package shift_issue_ctrl_pkg;
  localparam int WIDTH = 8;
  localparam int SHW   = 3;
  localparam int NREG  = 4;
  localparam int AW    = 2;

  typedef logic [1:0] state_t;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/barrel_shifters.sv
// rtl/barrel_shifters.sv - combinational logical left/right barrel shifters (s2/s1/s0 stages)
module left_shifter #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             s2,
  input  logic             s1,
  input  logic             s0,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] t2;
  logic [WIDTH-1:0] t1;

  assign t2 = s2 ? (a << 4)  : a;
  assign t1 = s1 ? (t2 << 2) : t2;
  assign y  = s0 ? (t1 << 1) : t1;
endmodule

module right_shifter #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic             s2,
  input  logic             s1,
  input  logic             s0,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] t2;
  logic [WIDTH-1:0] t1;

  assign t2 = s2 ? (a >> 4)  : a;
  assign t1 = s1 ? (t2 >> 2) : t2;
  assign y  = s0 ? (t1 >> 1) : t1;
endmodule

// File: rtl/shift_regarray.sv
// rtl/shift_regarray.sv - NREG x WIDTH register array, writeback-over-load write, two async reads
module shift_regarray
  import shift_issue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rs_addr,
  output logic [WIDTH-1:0] rs_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);
  logic [WIDTH-1:0] mem [NREG];

  // Per-entry decode so a load and a writeback to different entries both land
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_en && wb_addr == AW'(i))
          mem[i] <= wb_data;
        else if (ld_en && ld_addr == AW'(i))
          mem[i] <= ld_data;
      end
    end
  end

  assign rs_data  = mem[rs_addr];
  assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/shift_issue_ctrl.sv
// rtl/shift_issue_ctrl.sv - four-state read/shift/writeback sequencer around the barrel shifters
module shift_issue_ctrl
  import shift_issue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [SHW-1:0]   cmd_amt,
  input  logic [AW-1:0]    cmd_rs,
  input  logic [AW-1:0]    cmd_rd,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] done_data,
  output logic [AW-1:0]    done_rd
);
  state_t           state_q;
  logic             dir_q;
  logic [SHW-1:0]   amt_q;
  logic [AW-1:0]    rs_q;
  logic [AW-1:0]    rd_q;
  logic [WIDTH-1:0] op_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] sh_out;
  logic             wb_en;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wb_en     = (state_q == WRITE);

  left_shifter #(.WIDTH(WIDTH)) u_shl (
    .a  (op_q),
    .s2 (amt_q[2]),
    .s1 (amt_q[1]),
    .s0 (amt_q[0]),
    .y  (shl)
  );

  right_shifter #(.WIDTH(WIDTH)) u_shr (
    .a  (op_q),
    .s2 (amt_q[2]),
    .s1 (amt_q[1]),
    .s0 (amt_q[0]),
    .y  (shr)
  );

  assign sh_out = (dir_q == DIR_RIGHT) ? shr : shl;

  shift_regarray u_regs (
    .clk      (clk),
    .rst      (rst),
    .wb_en    (wb_en),
    .wb_addr  (rd_q),
    .wb_data  (res_q),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .rs_addr  (rs_q),
    .rs_data  (rs_data),
    .dbg_addr (rd_addr),
    .dbg_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      amt_q     <= '0;
      rs_q      <= '0;
      rd_q      <= '0;
      op_q      <= '0;
      res_q     <= '0;
      done      <= 1'b0;
      done_data <= '0;
      done_rd   <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            dir_q   <= cmd_dir;
            amt_q   <= cmd_amt;
            rs_q    <= cmd_rs;
            rd_q    <= cmd_rd;
            state_q <= READ;
          end
        end
        READ: begin
          // Array read sees the pre-edge value, so a same-edge load to rs is not used
          op_q    <= rs_data;
          state_q <= SHIFT;
        end
        SHIFT: begin
          res_q   <= sh_out;
          state_q <= WRITE;
        end
        default: begin
          done      <= 1'b1;
          done_data <= res_q;
          done_rd   <= rd_q;
          state_q   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_issue_ctrl.sv
// tb/tb_shift_issue_ctrl.sv - directed table-driven bench for shift_issue_ctrl
module tb_shift_issue_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [2:0] cmd_amt;
  logic [1:0] cmd_rs;
  logic [1:0] cmd_rd;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic [7:0] done_data;
  logic [1:0] done_rd;

  int checks = 0;
  int errors = 0;

  shift_issue_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_amt   (cmd_amt),
    .cmd_rs    (cmd_rs),
    .cmd_rd    (cmd_rd),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .done_data (done_data),
    .done_rd   (done_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       do_ld;
    logic [1:0] ld_a;
    logic [7:0] ld_v;
    logic       dir;
    logic [2:0] amt;
    logic [1:0] rs;
    logic [1:0] rd;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] v);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask

  task automatic issue(input logic dir, input logic [2:0] amt, input logic [1:0] rs, input logic [1:0] rd);
    cmd_dir = dir; cmd_amt = amt; cmd_rs = rs; cmd_rd = rd; cmd_valid = 1'b1;
    chk("ready_before_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 12) begin
      tick();
      n++;
    end
  endtask

  initial begin
    logic [7:0] v;
    int n;
    int low;
    int dones;

    vecs[0] = '{1'b1, 2'd1, 8'hB5, 1'b1, 3'd3, 2'd1, 2'd2, 8'h16};
    vecs[1] = '{1'b1, 2'd0, 8'h81, 1'b0, 3'd7, 2'd0, 2'd0, 8'h80};
    vecs[2] = '{1'b0, 2'd0, 8'h00, 1'b0, 3'd0, 2'd0, 2'd0, 8'h80};
    vecs[3] = '{1'b1, 2'd3, 8'hFF, 1'b0, 3'd3, 2'd3, 2'd1, 8'hF8};
    vecs[4] = '{1'b1, 2'd2, 8'h80, 1'b1, 3'd7, 2'd2, 2'd3, 8'h01};
    vecs[5] = '{1'b1, 2'd2, 8'h7F, 1'b1, 3'd7, 2'd2, 2'd2, 8'h00};
    vecs[6] = '{1'b1, 2'd1, 8'hC3, 1'b1, 3'd0, 2'd1, 2'd0, 8'hC3};

    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_amt = '0; cmd_rs = '0; cmd_rd = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_data", done_data, 0);
    chk("rst_done_rd", done_rd, 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      peek(2'(i), v);
      chk("rst_reg", v, 0);
    end

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_ld) load(vecs[i].ld_a, vecs[i].ld_v);
      issue(vecs[i].dir, vecs[i].amt, vecs[i].rs, vecs[i].rd);
      chk("busy_after_accept", busy, 1);
      wait_done(n);
      chk("latency", n, 3);
      chk("done_data", done_data, vecs[i].exp);
      chk("done_rd", done_rd, vecs[i].rd);
      peek(vecs[i].rd, v);
      chk("reg_writeback", v, vecs[i].exp);
      tick();
      chk("done_one_cycle", done, 0);
    end

    // cmd_valid held high across two commands
    load(2'd0, 8'h03);
    cmd_dir = 1'b0; cmd_amt = 3'd1; cmd_rs = 2'd0; cmd_rd = 2'd0; cmd_valid = 1'b1;
    tick();
    low = 0; dones = 0;
    for (int i = 0; i < 8; i++) begin
      chk("busy_mirrors_ready", busy, !cmd_ready);
      if (!cmd_ready) low++;
      if (done) dones++;
      if (i < 7) tick();
    end
    cmd_valid = 1'b0;
    chk("b2b_ready_low_cycles", low, 6);
    chk("b2b_done_count", dones, 2);
    peek(2'd0, v);
    chk("b2b_result", v, 8'h0C);
    tick();
    chk("b2b_no_third", busy, 0);

    // load collides with writeback on same address
    load(2'd2, 8'hF0);
    issue(1'b1, 3'd4, 2'd2, 2'd3);
    tick();
    tick();
    ld_en = 1'b1; ld_addr = 2'd3; ld_data = 8'hFF;
    tick();
    ld_en = 1'b0;
    chk("coll_done", done, 1);
    peek(2'd3, v);
    chk("coll_same_addr", v, 8'h0F);
    tick();

    // load and writeback on different addresses
    load(2'd3, 8'h55);
    issue(1'b1, 3'd4, 2'd2, 2'd3);
    tick();
    tick();
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 8'hAA;
    tick();
    ld_en = 1'b0;
    peek(2'd3, v);
    chk("coll_diff_wb", v, 8'h0F);
    peek(2'd1, v);
    chk("coll_diff_ld", v, 8'hAA);
    tick();

    // load to rs during READ must not affect the operand
    load(2'd0, 8'h40);
    issue(1'b0, 3'd1, 2'd0, 2'd1);
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 8'h01;
    tick();
    ld_en = 1'b0;
    wait_done(n);
    chk("read_old_latency", n, 2);
    chk("read_old_result", done_data, 8'h80);
    peek(2'd0, v);
    chk("read_old_load_kept", v, 8'h01);
    tick();

    // async reset during SHIFT
    load(2'd1, 8'h33);
    issue(1'b0, 3'd1, 2'd1, 2'd2);
    tick();
    chk("in_shift_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_ready", cmd_ready, 1);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      peek(2'(i), v);
      chk("async_reg_clear", v, 0);
    end
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) dones++;
      tick();
    end
    chk("abort_no_done", dones, 0);
    peek(2'd2, v);
    chk("abort_no_writeback", v, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
